// File: rtl/br_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writebacks.
// Latency 1 cycle accept->RegWrite; ready is combinational, one grant per cycle, write stage never stalls.
// Optional BR_ARB_FWD_EN adds combinational write-to-read forwarding for two read ports.
module br_write_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
`ifdef BR_ARB_FWD_EN
  input  logic [AW-1:0]    fwd_ra1,
  input  logic [AW-1:0]    fwd_ra2,
  input  logic [DW-1:0]    fwd_rd1,
  input  logic [DW-1:0]    fwd_rd2,
  output logic [DW-1:0]    fwd_q1,
  output logic [DW-1:0]    fwd_q2,
`endif
  output logic             RegWrite,
  output logic [AW-1:0]    WriteRegister,
  output logic [DW-1:0]    WriteData,
  output logic [CNT_W-1:0] a_grants,
  output logic [CNT_W-1:0] b_grants
);

  // ptr_q == 0 -> A has priority on contention, 1 -> B
  logic             ptr_q, ptr_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             grant_a, grant_b;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  assign grant_a = a_valid && (!b_valid || !ptr_q);
  assign grant_b = b_valid && (!a_valid ||  ptr_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    sel_addr  = grant_b ? b_addr : a_addr;
    sel_data  = grant_b ? b_data : a_data;
    if (grant_a) begin
      ptr_d = 1'b1;
      if (a_cnt_q != {CNT_W{1'b1}}) a_cnt_d = a_cnt_q + 1'b1;
    end
    if (grant_b) begin
      ptr_d = 1'b0;
      if (b_cnt_q != {CNT_W{1'b1}}) b_cnt_d = b_cnt_q + 1'b1;
    end
    // Writes to r0 complete the handshake but never reach the register file.
    if ((grant_a || grant_b) && (sel_addr != '0)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign RegWrite      = wr_en_q;
  assign WriteRegister = wr_addr_q;
  assign WriteData     = wr_data_q;
  assign a_grants      = a_cnt_q;
  assign b_grants      = b_cnt_q;

`ifdef BR_ARB_FWD_EN
  assign fwd_q1 = (wr_en_q && (wr_addr_q == fwd_ra1) && (fwd_ra1 != '0)) ? wr_data_q : fwd_rd1;
  assign fwd_q2 = (wr_en_q && (wr_addr_q == fwd_ra2) && (fwd_ra2 != '0)) ? wr_data_q : fwd_rd2;
`endif

endmodule

// File: tb/tb_br_write_arbiter.sv
// Directed self-checking bench for br_write_arbiter (CNT_W=4 so saturation is reachable).
module tb_br_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [CW-1:0] a_grants, b_grants;
`ifdef BR_ARB_FWD_EN
  logic [AW-1:0] fwd_ra1, fwd_ra2;
  logic [DW-1:0] fwd_rd1, fwd_rd2, fwd_q1, fwd_q2;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  br_write_arbiter #(.DW(DW), .AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
`ifdef BR_ARB_FWD_EN
    .fwd_ra1(fwd_ra1), .fwd_ra2(fwd_ra2), .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2),
    .fwd_q1(fwd_q1), .fwd_q2(fwd_q2),
`endif
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .a_grants(a_grants), .b_grants(b_grants)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
`ifdef BR_ARB_FWD_EN
    fwd_ra1 = '0; fwd_ra2 = '0; fwd_rd1 = '0; fwd_rd2 = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b wr=%0d wd=%h want 0 0 0", RegWrite, WriteRegister, WriteData);
    end
    tests++;
    if (a_grants !== 4'd0 || b_grants !== 4'd0) begin
      fails++;
      $display("FAIL reset_counters: got a=%0d b=%0d want 0 0", a_grants, b_grants);
    end
    step();
    rst_n = 1'b1;
    // Stream from A, then pull reset while the write is in flight.
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
    step();
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h0000_00AA;
    tests++;
    if (RegWrite !== 1'b1 || a_grants !== 4'd1) begin
      fails++;
      $display("FAIL reset_prewrite: got we=%b a=%0d want 1 1", RegWrite, a_grants);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (RegWrite !== 1'b0 || a_grants !== 4'd0 || b_grants !== 4'd0) begin
      fails++;
      $display("FAIL reset_midstream: got we=%b a=%0d b=%0d want 0 0 0", RegWrite, a_grants, b_grants);
    end
    step();
    rst_n = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_grant: got a_rdy=%b b_rdy=%b want 1 0", a_ready, b_ready);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_single();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_ready: got a_rdy=%b b_rdy=%b want 1 0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    tests++;
    if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEAD_BEEF || a_grants !== 4'd1) begin
      fails++;
      $display("FAIL single_write: got we=%b wr=%0d wd=%h a=%0d want 1 5 deadbeef 1",
               RegWrite, WriteRegister, WriteData, a_grants);
    end
    step();
    tests++;
    if (RegWrite !== 1'b0 || WriteRegister !== 5'd5 || WriteData !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL single_idle_hold: got we=%b wr=%0d wd=%h want 0 5 deadbeef", RegWrite, WriteRegister, WriteData);
    end
  endtask

  task automatic test_contention();
    int na = 0;
    int nb = 0;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1; a_addr = 5'(1 + na);  a_data = 32'(32'hA000 + na);
      b_valid = 1'b1; b_addr = 5'(11 + nb); b_data = 32'(32'hB000 + nb);
      #1;
      tests++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL contention_grant%0d: got a_rdy=%b b_rdy=%b want %b %b",
                 i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i % 2 == 0) begin exp_addr = 5'(1 + na); na++; end
      else            begin exp_addr = 5'(11 + nb); nb++; end
      step();
      tests++;
      if (RegWrite !== 1'b1 || WriteRegister !== exp_addr) begin
        fails++;
        $display("FAIL contention_write%0d: got we=%b wr=%0d want 1 %0d", i, RegWrite, WriteRegister, exp_addr);
      end
    end
    idle_inputs();
    tests++;
    if (a_grants !== 4'd3 || b_grants !== 4'd3) begin
      fails++;
      $display("FAIL contention_counts: got a=%0d b=%0d want 3 3", a_grants, b_grants);
    end
    step();
    tests++;
    if (RegWrite !== 1'b0) begin
      fails++;
      $display("FAIL contention_drain: got we=%b want 0", RegWrite);
    end
  endtask

  task automatic test_reg0();
    do_reset();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'd1;
    #1;
    tests++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL reg0_ready: got b_rdy=%b a_rdy=%b want 1 0", b_ready, a_ready);
    end
    step();
    idle_inputs();
    tests++;
    if (RegWrite !== 1'b0 || b_grants !== 4'd1 || a_grants !== 4'd0) begin
      fails++;
      $display("FAIL reg0_write: got we=%b b=%0d a=%0d want 0 1 0", RegWrite, b_grants, a_grants);
    end
    // Pointer moved to A after the B grant.
    a_valid = 1'b1; a_addr = 5'd2; b_valid = 1'b1; b_addr = 5'd3;
    #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL reg0_pointer: got a_rdy=%b b_rdy=%b want 1 0", a_ready, b_ready);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333_3333;
    for (int i = 0; i < 14; i++) step();
    tests++;
    if (a_grants !== 4'd14) begin
      fails++;
      $display("FAIL sat_count14: got %0d want 14", a_grants);
    end
    for (int i = 0; i < 6; i++) step();
    tests++;
    if (a_grants !== 4'd15 || RegWrite !== 1'b1) begin
      fails++;
      $display("FAIL sat_count20: got a=%0d we=%b want 15 1", a_grants, RegWrite);
    end
    step();
    idle_inputs();
    tests++;
    if (a_grants !== 4'd15) begin
      fails++;
      $display("FAIL sat_hold: got %0d want 15", a_grants);
    end
  endtask

`ifdef BR_ARB_FWD_EN
  task automatic test_forward();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_1234;
    fwd_ra1 = 5'd7; fwd_rd1 = 32'hAAAA_AAAA; fwd_ra2 = 5'd0; fwd_rd2 = 32'h5555_5555;
    #1;
    tests++;
    if (fwd_q1 !== 32'hAAAA_AAAA) begin
      fails++;
      $display("FAIL fwd_before: got %h want aaaaaaaa", fwd_q1);
    end
    step();
    a_valid = 1'b0;
    #1;
    tests++;
    if (fwd_q1 !== 32'h0000_1234 || fwd_q2 !== 32'h5555_5555) begin
      fails++;
      $display("FAIL fwd_write: got q1=%h q2=%h want 00001234 55555555", fwd_q1, fwd_q2);
    end
    step();
    tests++;
    if (fwd_q1 !== 32'hAAAA_AAAA) begin
      fails++;
      $display("FAIL fwd_after: got %h want aaaaaaaa", fwd_q1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_reg0();
`ifdef BR_ARB_FWD_EN
    test_forward();
`endif
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
